axi_lite_reg_slave: RTL

AXI4-Lite responder holding a bank of 32-bit software-visible registers. It is the slave end of the S00_AXI port of the controller IP and is driven by the PS or the AXI master VIP. It decouples the AW and W channels, applies byte strobes, flags out-of-range accesses with SLVERR, and exports the register contents and per-register write strobes to the controller fabric.

---
 rtl/controller_pkg.sv | 28 ++
 rtl/axi_lite_reg_slave.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and helpers for the AXI4-Lite register slave
package controller_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  // Word index of a byte address; the two byte-offset bits are dropped.
  function automatic int unsigned reg_index(input logic [31:0] addr);
    return 32'(addr >> 2);
  endfunction

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_data,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_data;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite register bank with decoupled AW/W capture
module axi_lite_reg_slave
  import controller_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [STRB_W-1:0]          S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int unsigned SLOTS = 2 ** (ADDR_W - 2);

  logic                aw_full;
  logic [ADDR_W-1:0]   aw_addr;
  logic                w_full;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                b_valid;
  axi_resp_t           b_resp;
  logic                r_valid;
  axi_resp_t           r_resp;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   rd_table [SLOTS];
  logic [NUM_REGS-1:0] wr_pulse;
  logic                commit;
  logic                ar_hs;
  int unsigned         wr_idx;
  int unsigned         rd_idx;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign commit      = aw_full & w_full & ~b_valid;
  assign ar_hs       = S_AXI_ARVALID & ~r_valid;
  assign wr_idx      = reg_index(32'(aw_addr));
  assign rd_idx      = reg_index(32'(S_AXI_ARADDR));
  assign wr_in_range = wr_idx < NUM_REGS;
  assign rd_in_range = rd_idx < NUM_REGS;

  // AW and W fill independently; both holding slots drain together on commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
      end else if (S_AXI_AWVALID && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (commit) begin
        w_full <= 1'b0;
      end else if (S_AXI_WVALID && !w_full) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      b_valid <= 1'b0;
      b_resp  <= OKAY;
    end else if (commit) begin
      b_valid <= 1'b1;
      b_resp  <= wr_in_range ? OKAY : SLVERR;
    end else if (S_AXI_BREADY) begin
      b_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg
    logic hit;
    assign hit = commit & wr_in_range & (wr_idx == k);

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        regs[k]     <= '0;
        wr_pulse[k] <= 1'b0;
      end else begin
        wr_pulse[k] <= hit;
        if (hit) regs[k] <= strb_merge(regs[k], w_data, w_strb);
      end
    end

    assign reg_q[DATA_W*k +: DATA_W] = regs[k];
  end

  // Every decodable slot has an entry so the read index needs no range guard.
  for (genvar k = 0; k < int'(SLOTS); k++) begin : g_rd
    if (k < int'(NUM_REGS)) begin : g_live
      assign rd_table[k] = regs[k];
    end else begin : g_empty
      assign rd_table[k] = '0;
    end
  end

  // Reads sample pre-commit register contents, so a same-edge write is not visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= OKAY;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= rd_table[S_AXI_ARADDR[ADDR_W-1:2]];
      r_resp  <= rd_in_range ? OKAY : SLVERR;
    end else if (S_AXI_RREADY) begin
      r_valid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = ~aw_full;
  assign S_AXI_WREADY  = ~w_full;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ~r_valid;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;
  assign reg_wr        = wr_pulse;

endmodule
